// File: rtl/crypto_seq_pkg.sv
// Shared types and default widths for the cipher-core sequencer.
package crypto_seq_pkg;

  localparam int KEY_W_DEF  = 128;
  localparam int DATA_W_DEF = 128;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    KEY_LOAD  = 3'd1,
    KEY_WAIT  = 3'd2,
    DATA_LOAD = 3'd3,
    DATA_WAIT = 3'd4,
    RESP      = 3'd5
  } seq_state_t;

endpackage

// File: rtl/crypto_core_sequencer_if.sv
// Requester-side job/result handshake bundle for crypto_core_sequencer.
interface crypto_core_sequencer_if
  import crypto_seq_pkg::*;
#(
  parameter int KEY_W  = KEY_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  logic              req_valid;
  logic              req_ready;
  logic              req_new_key;
  logic [KEY_W-1:0]  req_key;
  logic [DATA_W-1:0] req_data;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_err;

  modport master (
    output req_valid, req_new_key, req_key, req_data, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, req_new_key, req_key, req_data, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_err
  );

endinterface

// File: rtl/crypto_core_sequencer_timeout_cnt.sv
// Wait-state timeout counter; only built when SEQ_TIMEOUT_EN is defined.
`ifdef SEQ_TIMEOUT_EN
module seq_timeout_cnt #(
  parameter int unsigned LIMIT = 1024
) (
  input  logic CLK,
  input  logic RST,
  input  logic load,
  input  logic enable,
  output logic expire
);

  localparam int W = (LIMIT > 1) ? $clog2(LIMIT) : 1;

  logic [W-1:0] cnt;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                    cnt <= '0;
    else if (load)              cnt <= '0;
    else if (enable && !expire) cnt <= cnt + 1'b1;
  end

  assign expire = (cnt == W'(LIMIT - 1));

endmodule
`endif

// File: rtl/crypto_core_sequencer.sv
// Sequences key/data loads into a Krdy/Drdy block-cipher core for one requester.
// Optional wait-state timeout enabled by defining SEQ_TIMEOUT_EN.
module crypto_core_sequencer
  import crypto_seq_pkg::*;
#(
  parameter int KEY_W     = KEY_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int TO_CYCLES = 1024
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    EN,
  crypto_core_sequencer_if.slave  host,
  output logic                    Krdy,
  output logic [KEY_W-1:0]        Kin,
  output logic                    Drdy,
  output logic [DATA_W-1:0]       Din,
  input  logic                    Kvld,
  input  logic                    Dvld,
  input  logic [DATA_W-1:0]       Dout,
  input  logic                    BSY
);

  seq_state_t        state_q, state_d;
  logic              key_loaded_q;
  logic              kvld_pend_q, dvld_pend_q;
  logic [DATA_W-1:0] dout_pend_q;
  logic [DATA_W-1:0] rsp_data_q;
  logic              kvld_eff, dvld_eff, accept, go_key, abort;
  logic [DATA_W-1:0] dout_sel;

  // Core pulses seen while frozen are replayed once EN returns.
  assign kvld_eff = Kvld | kvld_pend_q;
  assign dvld_eff = Dvld | dvld_pend_q;
  assign dout_sel = Dvld ? Dout : dout_pend_q;
  assign accept   = host.req_valid & host.req_ready;
  assign go_key   = host.req_new_key | ~key_loaded_q;

`ifdef SEQ_TIMEOUT_EN
  logic to_expire, to_load, rsp_err_q;

  assign to_load = (state_q != KEY_WAIT) && (state_q != DATA_WAIT);
  assign abort   = to_expire &&
                   (((state_q == KEY_WAIT) && !kvld_eff) ||
                    ((state_q == DATA_WAIT) && !dvld_eff));

  seq_timeout_cnt #(.LIMIT(TO_CYCLES)) u_timeout (
    .CLK    (CLK),
    .RST    (RST),
    .load   (to_load),
    .enable (EN & ~to_load),
    .expire (to_expire)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                                            rsp_err_q <= 1'b0;
    else if (EN && abort)                               rsp_err_q <= 1'b1;
    else if (EN && state_q == RESP && host.rsp_ready)   rsp_err_q <= 1'b0;
  end

  assign host.rsp_err = rsp_err_q;
`else
  assign abort        = 1'b0;
  assign host.rsp_err = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)     state_q <= IDLE;
    else if (EN) state_q <= state_d;
  end

  // NOTE: state_d is defaulted before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:      if (accept) state_d = go_key ? KEY_LOAD : DATA_LOAD;
      KEY_LOAD:  state_d = KEY_WAIT;
      KEY_WAIT:  if (kvld_eff) state_d = DATA_LOAD;
                 else if (abort) state_d = RESP;
      DATA_LOAD: state_d = DATA_WAIT;
      DATA_WAIT: if (dvld_eff || abort) state_d = RESP;
      RESP:      if (host.rsp_ready) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    host.req_ready = (state_q == IDLE) && EN && !BSY && !RST;
    host.rsp_valid = (state_q == RESP);
    Krdy           = EN && (state_q == KEY_LOAD);
    Drdy           = EN && (state_q == DATA_LOAD);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      Kin          <= '0;
      Din          <= '0;
      rsp_data_q   <= '0;
      key_loaded_q <= 1'b0;
      kvld_pend_q  <= 1'b0;
      dvld_pend_q  <= 1'b0;
      dout_pend_q  <= '0;
    end else if (!EN) begin
      if (Kvld) kvld_pend_q <= 1'b1;
      if (Dvld) begin
        dvld_pend_q <= 1'b1;
        dout_pend_q <= Dout;
      end
    end else begin
      kvld_pend_q <= 1'b0;
      dvld_pend_q <= 1'b0;
      if (accept) begin
        Din <= host.req_data;
        if (go_key) Kin <= host.req_key;
      end
      if (state_q == KEY_WAIT && kvld_eff)  key_loaded_q <= 1'b1;
      if (state_q == DATA_WAIT && dvld_eff) rsp_data_q   <= dout_sel;
      // A timed-out core is in an unknown key state, so force a reload next job.
      if (abort) begin
        rsp_data_q   <= '0;
        key_loaded_q <= 1'b0;
      end
    end
  end

  assign host.rsp_data = rsp_data_q;

endmodule

// File: tb/tb_crypto_core_sequencer.sv
// Directed bench for crypto_core_sequencer; exercises the timeout path when SEQ_TIMEOUT_EN is defined.
module tb_crypto_core_sequencer;
  import crypto_seq_pkg::*;

  localparam int KW = 128;
  localparam int DW = 128;
`ifdef SEQ_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 1024;
`endif

  localparam logic [KW-1:0] K0 = {4{32'h0011_2233}};
  localparam logic [KW-1:0] K1 = {4{32'h4455_6677}};
  localparam logic [KW-1:0] K2 = {4{32'h8899_AABB}};
  localparam logic [KW-1:0] K7 = {4{32'hCCDD_EEFF}};
  localparam logic [DW-1:0] D0 = {4{32'hD000_0000}};
  localparam logic [DW-1:0] D1 = {4{32'hD111_1111}};
  localparam logic [DW-1:0] D2 = {4{32'hD222_2222}};
  localparam logic [DW-1:0] D3 = {4{32'hD333_3333}};
  localparam logic [DW-1:0] D4 = {4{32'hD444_4444}};
  localparam logic [DW-1:0] D5 = {4{32'hD555_5555}};
  localparam logic [DW-1:0] D7 = {4{32'hD777_7777}};
  localparam logic [DW-1:0] R0 = {4{32'hA000_0001}};
  localparam logic [DW-1:0] R1 = {4{32'hA111_0002}};
  localparam logic [DW-1:0] R2 = {4{32'hA222_0003}};
  localparam logic [DW-1:0] R3 = {4{32'hA333_0004}};
  localparam logic [DW-1:0] R4 = {4{32'hA444_0005}};
  localparam logic [DW-1:0] R5 = {4{32'hA555_0006}};
  localparam logic [DW-1:0] R7 = {4{32'hA777_0007}};

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          EN  = 1'b1;
  logic          Krdy, Drdy;
  logic [KW-1:0] Kin;
  logic [DW-1:0] Din;
  logic          Kvld = 1'b0;
  logic          Dvld = 1'b0;
  logic [DW-1:0] Dout = '0;
  logic          BSY  = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  crypto_core_sequencer_if #(.KEY_W(KW), .DATA_W(DW)) host ();

  crypto_core_sequencer #(.KEY_W(KW), .DATA_W(DW), .TO_CYCLES(TO)) dut (
    .CLK  (CLK),
    .RST  (RST),
    .EN   (EN),
    .host (host),
    .Krdy (Krdy),
    .Kin  (Kin),
    .Drdy (Drdy),
    .Din  (Din),
    .Kvld (Kvld),
    .Dvld (Dvld),
    .Dout (Dout),
    .BSY  (BSY)
  );

  assert property (@(posedge CLK) disable iff (RST) !(Krdy && Drdy))
    else begin
      errors++;
      $display("FAIL strobe_overlap Krdy=%b Drdy=%b", Krdy, Drdy);
    end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic offer(input logic new_key, input logic [KW-1:0] key, input logic [DW-1:0] data);
    host.req_valid   = 1'b1;
    host.req_new_key = new_key;
    host.req_key     = key;
    host.req_data    = data;
  endtask

  task automatic ack();
    host.rsp_ready = 1'b1;
    tick();
    host.rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    checks++; if (host.req_ready !== 1'b0) begin errors++; $display("FAIL rst_req_ready got %b want 0", host.req_ready); end
    checks++; if (host.rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid got %b want 0", host.rsp_valid); end
    checks++; if (host.rsp_err !== 1'b0) begin errors++; $display("FAIL rst_rsp_err got %b want 0", host.rsp_err); end
    checks++; if ({Krdy, Drdy} !== 2'b00) begin errors++; $display("FAIL rst_strobes got %b want 00", {Krdy, Drdy}); end
    checks++; if (Kin !== '0 || Din !== '0) begin errors++; $display("FAIL rst_kin_din got %h/%h want 0", Kin, Din); end
    checks++; if (host.rsp_data !== '0) begin errors++; $display("FAIL rst_rsp_data got %h want 0", host.rsp_data); end
    tick();
    RST = 1'b0;
    #1;
    checks++; if (host.req_ready !== 1'b1) begin errors++; $display("FAIL idle_req_ready got %b want 1", host.req_ready); end
    BSY = 1'b1; #1;
    checks++; if (host.req_ready !== 1'b0) begin errors++; $display("FAIL bsy_req_ready got %b want 0", host.req_ready); end
    BSY = 1'b0; EN = 1'b0; #1;
    checks++; if (host.req_ready !== 1'b0) begin errors++; $display("FAIL en0_req_ready got %b want 0", host.req_ready); end
    EN = 1'b1;
  endtask

  task automatic test_new_key();
    offer(1'b1, K0, D0);
    tick();
    host.req_valid = 1'b0;
    checks++; if (Krdy !== 1'b1 || Drdy !== 1'b0) begin errors++; $display("FAIL nk_krdy got %b%b want 10", Krdy, Drdy); end
    checks++; if (Kin !== K0) begin errors++; $display("FAIL nk_kin got %h want %h", Kin, K0); end
    checks++; if (host.req_ready !== 1'b0) begin errors++; $display("FAIL nk_req_ready got %b want 0", host.req_ready); end
    tick();
    checks++; if (Krdy !== 1'b0) begin errors++; $display("FAIL nk_krdy_once got %b want 0", Krdy); end
    Kvld = 1'b1; tick(); Kvld = 1'b0;
    checks++; if (Drdy !== 1'b1 || Din !== D0) begin errors++; $display("FAIL nk_drdy got %b/%h want 1/%h", Drdy, Din, D0); end
    tick();
    checks++; if (Drdy !== 1'b0) begin errors++; $display("FAIL nk_drdy_once got %b want 0", Drdy); end
    Dvld = 1'b1; Dout = R0; tick(); Dvld = 1'b0; Dout = '0;
    checks++; if (host.rsp_valid !== 1'b1 || host.rsp_data !== R0 || host.rsp_err !== 1'b0)
      begin errors++; $display("FAIL nk_rsp got v=%b d=%h e=%b want 1/%h/0", host.rsp_valid, host.rsp_data, host.rsp_err, R0); end
    ack();
    checks++; if (host.rsp_valid !== 1'b0 || host.req_ready !== 1'b1)
      begin errors++; $display("FAIL nk_done got v=%b rdy=%b want 0/1", host.rsp_valid, host.req_ready); end
  endtask

  task automatic test_reuse();
    offer(1'b0, K1, D1);
    tick();
    host.req_valid = 1'b0;
    checks++; if (Krdy !== 1'b0 || Drdy !== 1'b1 || Din !== D1)
      begin errors++; $display("FAIL ru_drdy got k=%b d=%b din=%h want 0/1/%h", Krdy, Drdy, Din, D1); end
    tick();
    Dvld = 1'b1; Dout = R1; tick(); Dvld = 1'b0;
    checks++; if (host.rsp_valid !== 1'b1 || host.rsp_data !== R1)
      begin errors++; $display("FAIL ru_rsp got v=%b d=%h want 1/%h", host.rsp_valid, host.rsp_data, R1); end
    ack();
  endtask

  task automatic test_stall();
    offer(1'b1, K2, D2);
    tick();
    host.req_valid = 1'b0;
    checks++; if (Krdy !== 1'b1 || Kin !== K2) begin errors++; $display("FAIL st_krdy got %b/%h want 1/%h", Krdy, Kin, K2); end
    tick();
    EN = 1'b0;
    for (int i = 0; i < 5; i++) begin
      Kvld = (i == 2);
      tick();
      checks++; if ({Krdy, Drdy} !== 2'b00) begin errors++; $display("FAIL st_frozen_%0d got %b want 00", i, {Krdy, Drdy}); end
    end
    Kvld = 1'b0; EN = 1'b1; #1;
    checks++; if (Drdy !== 1'b0) begin errors++; $display("FAIL st_early_drdy got %b want 0", Drdy); end
    tick();
    checks++; if (Drdy !== 1'b1 || Din !== D2) begin errors++; $display("FAIL st_drdy got %b/%h want 1/%h", Drdy, Din, D2); end
    tick();
    Dvld = 1'b1; Dout = R2; tick(); Dvld = 1'b0;
    checks++; if (host.rsp_valid !== 1'b1 || host.rsp_data !== R2)
      begin errors++; $display("FAIL st_rsp got v=%b d=%h want 1/%h", host.rsp_valid, host.rsp_data, R2); end
    ack();
  endtask

  task automatic test_backpressure();
    offer(1'b0, K2, D3);
    tick();
    host.req_valid = 1'b0;
    checks++; if (Drdy !== 1'b1) begin errors++; $display("FAIL bp_drdy got %b want 1", Drdy); end
    tick();
    Dvld = 1'b1; Dout = R3; tick(); Dvld = 1'b0; Dout = R7;
    offer(1'b0, K2, D4);
    for (int i = 0; i < 4; i++) begin
      checks++; if (host.rsp_valid !== 1'b1 || host.rsp_data !== R3 || host.req_ready !== 1'b0)
        begin errors++; $display("FAIL bp_hold_%0d got v=%b d=%h rdy=%b want 1/%h/0", i, host.rsp_valid, host.rsp_data, host.req_ready, R3); end
      tick();
    end
    host.rsp_ready = 1'b1; #1;
    checks++; if (host.req_ready !== 1'b0) begin errors++; $display("FAIL bp_same_cycle got %b want 0", host.req_ready); end
    tick();
    host.rsp_ready = 1'b0;
    checks++; if (host.rsp_valid !== 1'b0 || host.req_ready !== 1'b1)
      begin errors++; $display("FAIL bp_after got v=%b rdy=%b want 0/1", host.rsp_valid, host.req_ready); end
    tick();
    host.req_valid = 1'b0;
    checks++; if (Drdy !== 1'b1 || Din !== D4) begin errors++; $display("FAIL bp_next got %b/%h want 1/%h", Drdy, Din, D4); end
    tick();
    Dvld = 1'b1; Dout = R4; tick(); Dvld = 1'b0;
    checks++; if (host.rsp_data !== R4) begin errors++; $display("FAIL bp_next_rsp got %h want %h", host.rsp_data, R4); end
    ack();
  endtask

  task automatic test_timeout();
    offer(1'b0, K2, D5);
    tick();
    host.req_valid = 1'b0;
    tick();
`ifdef SEQ_TIMEOUT_EN
    repeat (7) tick();
    checks++; if (host.rsp_valid !== 1'b0) begin errors++; $display("FAIL to_early got %b want 0", host.rsp_valid); end
    tick();
    checks++; if (host.rsp_valid !== 1'b1 || host.rsp_err !== 1'b1 || host.rsp_data !== '0)
      begin errors++; $display("FAIL to_rsp got v=%b e=%b d=%h want 1/1/0", host.rsp_valid, host.rsp_err, host.rsp_data); end
    ack();
    offer(1'b0, K1, D5);
    tick();
    host.req_valid = 1'b0;
    checks++; if (Krdy !== 1'b1 || Kin !== K1) begin errors++; $display("FAIL to_reload got %b/%h want 1/%h", Krdy, Kin, K1); end
    tick();
    Kvld = 1'b1; tick(); Kvld = 1'b0;
    tick();
`else
    for (int i = 0; i < 20; i++) begin
      checks++; if (host.rsp_valid !== 1'b0 || host.rsp_err !== 1'b0)
        begin errors++; $display("FAIL nto_wait_%0d got v=%b e=%b want 0/0", i, host.rsp_valid, host.rsp_err); end
      tick();
    end
`endif
    Dvld = 1'b1; Dout = R5; tick(); Dvld = 1'b0;
    checks++; if (host.rsp_valid !== 1'b1 || host.rsp_data !== R5 || host.rsp_err !== 1'b0)
      begin errors++; $display("FAIL to_good got v=%b d=%h e=%b want 1/%h/0", host.rsp_valid, host.rsp_data, host.rsp_err, R5); end
    ack();
  endtask

  task automatic test_reset_mid();
    offer(1'b1, K0, D1);
    tick();
    host.req_valid = 1'b0;
    tick();
    Kvld = 1'b1; tick(); Kvld = 1'b0;
    tick();
    #3 RST = 1'b1;
    #1;
    checks++; if ({Krdy, Drdy, host.req_ready, host.rsp_valid, host.rsp_err} !== 5'b0)
      begin errors++; $display("FAIL mr_ctrl got %b want 00000", {Krdy, Drdy, host.req_ready, host.rsp_valid, host.rsp_err}); end
    checks++; if (Kin !== '0 || Din !== '0 || host.rsp_data !== '0)
      begin errors++; $display("FAIL mr_data got %h/%h/%h want 0", Kin, Din, host.rsp_data); end
    tick();
    RST = 1'b0;
    Kvld = 1'b1; tick(); Kvld = 1'b0;
    offer(1'b0, K7, D7);
    tick();
    host.req_valid = 1'b0;
    checks++; if (Krdy !== 1'b1 || Drdy !== 1'b0 || Kin !== K7)
      begin errors++; $display("FAIL mr_reload got %b%b/%h want 10/%h", Krdy, Drdy, Kin, K7); end
    tick();
    Kvld = 1'b1; tick(); Kvld = 1'b0;
    checks++; if (Drdy !== 1'b1 || Din !== D7) begin errors++; $display("FAIL mr_drdy got %b/%h want 1/%h", Drdy, Din, D7); end
    tick();
    Dvld = 1'b1; Dout = R7; tick(); Dvld = 1'b0;
    checks++; if (host.rsp_valid !== 1'b1 || host.rsp_data !== R7)
      begin errors++; $display("FAIL mr_rsp got v=%b d=%h want 1/%h", host.rsp_valid, host.rsp_data, R7); end
    ack();
  endtask

  initial begin
    host.req_valid   = 1'b0;
    host.req_new_key = 1'b0;
    host.req_key     = '0;
    host.req_data    = '0;
    host.rsp_ready   = 1'b0;
    test_reset();
    test_new_key();
    test_reuse();
    test_stall();
    test_backpressure();
    test_timeout();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
